write_port_packer: RTL and testbench

WRITE_PORT_PACKER -- requirements
Module: write_port_packer

---
 rtl/write_port_packer_if.sv | 33 +++
 rtl/write_port_packer.sv | 98 +++++++++
 tb/tb_write_port_packer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/write_port_packer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// write_port_packer_if -- request, stall and packed write-port bundle. Rev 1.0
// ---------------------------------------------------------------------------
interface write_port_packer_if #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 4,
  parameter int NUM_WRITE_PORTS = 4,
  parameter int FIFO_DEPTH      = 8
);
  localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

  logic                                  in_valid;
  logic                                  in_ready;
  logic [ADDR_WIDTH-1:0]                 in_addr;
  logic [DATA_WIDTH-1:0]                 in_data;
  logic                                  mem_hold;
  logic [NUM_WRITE_PORTS-1:0]            we;
  logic [NUM_WRITE_PORTS*ADDR_WIDTH-1:0] waddr;
  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wdata;
  logic [COUNT_WIDTH-1:0]                count;

  modport master (
    output in_valid, in_addr, in_data, mem_hold,
    input  in_ready, we, waddr, wdata, count
  );

  modport slave (
    input  in_valid, in_addr, in_data, mem_hold,
    output in_ready, we, waddr, wdata, count
  );
endinterface
`default_nettype wire

// File: rtl/write_port_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// write_port_packer -- buffers write requests and issues up to NUM_WRITE_PORTS
// address-distinct writes per cycle in arrival order. Rev 1.0
// ---------------------------------------------------------------------------
module write_port_packer #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 4,
  parameter int NUM_WRITE_PORTS = 4,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                clk,
  input  logic                rst,
  write_port_packer_if.slave  bus
);
  localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
  localparam int COUNT_WIDTH = PTR_WIDTH + 1;
  localparam int K_WIDTH     = $clog2(NUM_WRITE_PORTS + 1);

  logic [ADDR_WIDTH-1:0]                 addr_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]                 data_mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]                  head;
  logic [PTR_WIDTH-1:0]                  tail;
  logic [COUNT_WIDTH-1:0]                count;
  logic                                  live;
  logic [NUM_WRITE_PORTS-1:0]            we;
  logic [NUM_WRITE_PORTS*ADDR_WIDTH-1:0] waddr;
  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0]                 peek_addr [NUM_WRITE_PORTS];
  logic [DATA_WIDTH-1:0]                 peek_data [NUM_WRITE_PORTS];
  logic [K_WIDTH-1:0]                    k;
  logic                                  stop;
  logic                                  in_ready;
  logic                                  push;

  // The oldest NUM_WRITE_PORTS entries; pointer arithmetic wraps naturally.
  generate
    for (genvar i = 0; i < NUM_WRITE_PORTS; i++) begin : g_peek
      assign peek_addr[i] = addr_mem[head + PTR_WIDTH'(i)];
      assign peek_data[i] = data_mem[head + PTR_WIDTH'(i)];
    end
  endgenerate

  // live keeps in_ready low throughout reset and for the cycle after release.
  assign in_ready = live && (count < COUNT_WIDTH'(FIFO_DEPTH));
  assign push     = bus.in_valid && in_ready;

  // Drain stops at the first empty slot or the first repeated address.
  always_comb begin
    k    = '0;
    stop = bus.mem_hold;
    for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
      if (!stop) begin
        if (COUNT_WIDTH'(i) >= count) stop = 1'b1;
        for (int j = 0; j < NUM_WRITE_PORTS; j++) begin
          if (j < i && peek_addr[j] == peek_addr[i]) stop = 1'b1;
        end
        if (!stop) k = K_WIDTH'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= bus.in_addr;
      data_mem[tail] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      live  <= 1'b0;
      we    <= '0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      live  <= 1'b1;
      if (push) tail <= tail + PTR_WIDTH'(1);
      head  <= head + PTR_WIDTH'(k);
      count <= count + COUNT_WIDTH'(push) - COUNT_WIDTH'(k);
      for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
        we[i]                              <= (K_WIDTH'(i) < k);
        waddr[i*ADDR_WIDTH +: ADDR_WIDTH]  <= (K_WIDTH'(i) < k) ? peek_addr[i] : '0;
        wdata[i*DATA_WIDTH +: DATA_WIDTH]  <= (K_WIDTH'(i) < k) ? peek_data[i] : '0;
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.we       = we;
  assign bus.waddr    = waddr;
  assign bus.wdata    = wdata;
  assign bus.count    = count;
endmodule
`default_nettype wire

// File: tb/tb_write_port_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_write_port_packer -- directed vector table, reset sequences and random
// traffic against a queue-based reference of the packer. Rev 1.0
// ---------------------------------------------------------------------------
module tb_write_port_packer;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int NP    = 4;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int NV    = 28;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  write_port_packer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WRITE_PORTS(NP),
                         .FIFO_DEPTH(DEPTH)) bus ();

  write_port_packer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WRITE_PORTS(NP),
                      .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          h;
    logic [NP-1:0] e_we;
    logic [15:0]   e_wa;
    logic [31:0]   e_wd;
    logic [CW-1:0] e_cnt;
    logic          e_rdy;
  } vec_t;

  ent_t          q[$];
  logic          live_m;
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] dut_mem [16];
  vec_t          vt [NV];
  int            checks   = 0;
  int            failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: predict from the queue, apply inputs, compare after the edge.
  task automatic tick(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic h);
    int               k;
    logic [15:0]      seen;
    logic [NP-1:0]    e_we;
    logic [NP*AW-1:0] e_wa;
    logic [NP*DW-1:0] e_wd;
    logic             rdy;
    rdy  = live_m && (q.size() < DEPTH);
    k    = 0;
    seen = '0;
    e_we = '0;
    e_wa = '0;
    e_wd = '0;
    if (!h) begin
      while (k < NP && k < q.size() && !seen[q[k].a]) begin
        seen[q[k].a]       = 1'b1;
        e_we[k]            = 1'b1;
        e_wa[k*AW +: AW]   = q[k].a;
        e_wd[k*DW +: DW]   = q[k].d;
        k++;
      end
    end
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.mem_hold = h;
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, rdy});
    @(posedge clk);
    #1;
    repeat (k) void'(q.pop_front());
    if (v && rdy) begin
      q.push_back('{a: a, d: d});
      ref_mem[a] = d;
    end
    live_m = 1'b1;
    chk("model_we", {60'd0, bus.we}, {60'd0, e_we});
    chk("model_waddr", {48'd0, bus.waddr}, {48'd0, e_wa});
    chk("model_wdata", {32'd0, bus.wdata}, {32'd0, e_wd});
    chk("model_count", {60'd0, bus.count}, 64'(q.size()));
    for (int p = 0; p < NP; p++)
      if (bus.we[p]) dut_mem[bus.waddr[p*AW +: AW]] = bus.wdata[p*DW +: DW];
    checks++;
    if (bus.count > CW'(DEPTH)) begin
      failures++;
      $display("FAIL count_max: got %0d limit %0d", bus.count, DEPTH);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // v a d h | we waddr wdata count ready (outputs after the edge)
    vt = '{
      '{1'b1, 4'h3, 8'hA5, 1'b0, 4'b0000, 16'h0000, 32'h00000000, 4'd1, 1'b1},
      '{1'b0, 4'h0, 8'h00, 1'b0, 4'b0001, 16'h0003, 32'h000000A5, 4'd0, 1'b1},
      '{1'b0, 4'h0, 8'h00, 1'b0, 4'b0000, 16'h0000, 32'h00000000, 4'd0, 1'b1},
      '{1'b1, 4'h1, 8'h11, 1'b1, 4'b0000, 16'h0000, 32'h00000000, 4'd1, 1'b1},
      '{1'b1, 4'h2, 8'h12, 1'b1, 4'b0000, 16'h0000, 32'h00000000, 4'd2, 1'b1},
      '{1'b1, 4'h3, 8'h13, 1'b1, 4'b0000, 16'h0000, 32'h00000000, 4'd3, 1'b1},
      '{1'b1, 4'h4, 8'h14, 1'b1, 4'b0000, 16'h0000, 32'h00000000, 4'd4, 1'b1},
      '{1'b1, 4'h5, 8'h15, 1'b1, 4'b0000, 16'h0000, 32'h00000000, 4'd5, 1'b1},
      '{1'b0, 4'h0, 8'h00, 1'b0, 4'b1111, 16'h4321, 32'h14131211, 4'd1, 1'b1},
      '{1'b0, 4'h0, 8'h00, 1'b0, 4'b0001, 16'h0005, 32'h00000015, 4'd0, 1'b1},
      '{1'b0, 4'h0, 8'h00, 1'b0, 4'b0000, 16'h0000, 32'h00000000, 4'd0, 1'b1},
      '{1'b1, 4'h7, 8'h21, 1'b1, 4'b0000, 16'h0000, 32'h00000000, 4'd1, 1'b1},
      '{1'b1, 4'h2, 8'h22, 1'b1, 4'b0000, 16'h0000, 32'h00000000, 4'd2, 1'b1},
      '{1'b1, 4'h7, 8'h23, 1'b1, 4'b0000, 16'h0000, 32'h00000000, 4'd3, 1'b1},
      '{1'b1, 4'h9, 8'h24, 1'b1, 4'b0000, 16'h0000, 32'h00000000, 4'd4, 1'b1},
      '{1'b0, 4'h0, 8'h00, 1'b0, 4'b0011, 16'h0027, 32'h00002221, 4'd2, 1'b1},
      '{1'b0, 4'h0, 8'h00, 1'b0, 4'b0011, 16'h0097, 32'h00002423, 4'd0, 1'b1},
      '{1'b1, 4'h0, 8'h30, 1'b1, 4'b0000, 16'h0000, 32'h00000000, 4'd1, 1'b1},
      '{1'b1, 4'h1, 8'h31, 1'b1, 4'b0000, 16'h0000, 32'h00000000, 4'd2, 1'b1},
      '{1'b1, 4'h2, 8'h32, 1'b1, 4'b0000, 16'h0000, 32'h00000000, 4'd3, 1'b1},
      '{1'b1, 4'h3, 8'h33, 1'b1, 4'b0000, 16'h0000, 32'h00000000, 4'd4, 1'b1},
      '{1'b1, 4'h4, 8'h34, 1'b1, 4'b0000, 16'h0000, 32'h00000000, 4'd5, 1'b1},
      '{1'b1, 4'h5, 8'h35, 1'b1, 4'b0000, 16'h0000, 32'h00000000, 4'd6, 1'b1},
      '{1'b1, 4'h6, 8'h36, 1'b1, 4'b0000, 16'h0000, 32'h00000000, 4'd7, 1'b1},
      '{1'b1, 4'h7, 8'h37, 1'b1, 4'b0000, 16'h0000, 32'h00000000, 4'd8, 1'b0},
      '{1'b1, 4'hF, 8'hFF, 1'b1, 4'b0000, 16'h0000, 32'h00000000, 4'd8, 1'b0},
      '{1'b0, 4'h0, 8'h00, 1'b0, 4'b1111, 16'h3210, 32'h33323130, 4'd4, 1'b1},
      '{1'b0, 4'h0, 8'h00, 1'b0, 4'b1111, 16'h7654, 32'h37363534, 4'd0, 1'b1}
    };
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.mem_hold = 1'b0;
    live_m       = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = '0;
      dut_mem[i] = '0;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_we", {60'd0, bus.we}, 64'd0);
    chk("rst_count", {60'd0, bus.count}, 64'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    live_m = 1'b1;
    chk("release_in_ready", {63'd0, bus.in_ready}, 64'd1);

    for (int i = 0; i < NV; i++) begin
      tick(vt[i].v, vt[i].a, vt[i].d, vt[i].h);
      chk($sformatf("vec%0d_we", i), {60'd0, bus.we}, {60'd0, vt[i].e_we});
      chk($sformatf("vec%0d_waddr", i), {48'd0, bus.waddr}, {48'd0, vt[i].e_wa});
      chk($sformatf("vec%0d_wdata", i), {32'd0, bus.wdata}, {32'd0, vt[i].e_wd});
      chk($sformatf("vec%0d_count", i), {60'd0, bus.count}, {60'd0, vt[i].e_cnt});
      chk($sformatf("vec%0d_ready", i), {63'd0, bus.in_ready}, {63'd0, vt[i].e_rdy});
    end

    // Same-address run drains one per cycle, leaving five entries at reset.
    for (int i = 0; i < 6; i++) tick(1'b1, 4'h1, DW'(8'h40 + i), 1'b1);
    tick(1'b0, 4'h0, 8'h00, 1'b0);
    chk("pre_reset_we", {60'd0, bus.we}, 64'd1);
    chk("pre_reset_count", {60'd0, bus.count}, 64'd5);
    #2 rst = 1'b1;
    #1;
    chk("async_we", {60'd0, bus.we}, 64'd0);
    chk("async_waddr", {48'd0, bus.waddr}, 64'd0);
    chk("async_wdata", {32'd0, bus.wdata}, 64'd0);
    chk("async_count", {60'd0, bus.count}, 64'd0);
    chk("async_in_ready", {63'd0, bus.in_ready}, 64'd0);
    q.delete();
    live_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    live_m = 1'b1;
    chk("rerelease_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rerelease_we", {60'd0, bus.we}, 64'd0);
    repeat (3) tick(1'b0, 4'h0, 8'h00, 1'b0);

    // Random traffic with periodic stall bursts and a narrow address range.
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = '0;
      dut_mem[i] = '0;
    end
    for (int c = 0; c < 160; c++)
      tick($urandom_range(0, 3) != 0, AW'($urandom_range(0, 3)), DW'($urandom),
           (c % 16) < 7);
    repeat (12) tick(1'b0, 4'h0, 8'h00, 1'b0);
    chk("final_count", {60'd0, bus.count}, 64'd0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("mem_%0d", i), {56'd0, dut_mem[i]}, {56'd0, ref_mem[i]});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
